// File: rtl/cam_write_arbiter_if.sv
// Requester, response, CAM write-port and status bundle for
// cam_write_arbiter.
interface cam_write_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REQ    = 2
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_op;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;

   logic                          resp_valid;
   logic                          resp_ready;
   logic [2:0]                    resp_port;
   logic [ADDR_WIDTH-1:0]         resp_addr;
   logic                          resp_err;

   logic [ADDR_WIDTH-1:0]         cam_write_addr;
   logic [DATA_WIDTH-1:0]         cam_write_data;
   logic                          cam_write_delete;
   logic                          cam_write_enable;
   logic                          cam_write_busy;

   logic [ADDR_WIDTH:0]           free_count;
   logic                          full;

   modport slave (
      input  req_valid, req_op, req_data, req_addr,
      output req_ready,
      output resp_valid, resp_port, resp_addr, resp_err,
      input  resp_ready,
      output cam_write_addr, cam_write_data,
      output cam_write_delete, cam_write_enable,
      input  cam_write_busy,
      output free_count, full
   );

   modport master (
      output req_valid, req_op, req_data, req_addr,
      input  req_ready,
      input  resp_valid, resp_port, resp_addr, resp_err,
      output resp_ready,
      input  cam_write_addr, cam_write_data,
      input  cam_write_delete, cam_write_enable,
      output cam_write_busy,
      input  free_count, full
   );
endinterface

// File: rtl/cam_write_arbiter.sv
// Round-robin arbiter serialising insert/delete commands onto a
// single CAM write port, with free-entry bitmap allocation.
module cam_write_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REQ    = 2
) (
   input logic                clk,
   input logic                rst,
   cam_write_arbiter_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      INIT, IDLE, ISSUE, WAIT, RESP
   } state_t;

   state_t state, state_nxt;

   logic [2:0]            rr_ptr;
   logic [2:0]            cand;
   logic [2:0]            gnt_idx;
   logic                  gnt_found;
   logic                  hs;
   logic                  cam_en;
   logic                  wait_first;
   logic                  full_int;
   logic [NUM_REQ-1:0]    ready;

   logic [DEPTH-1:0]      valid_map;
   logic [ADDR_WIDTH:0]   free_cnt;
   logic [ADDR_WIDTH-1:0] low_idx;

   logic                  sel_op;
   logic                  sel_err;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [ADDR_WIDTH-1:0] tgt_addr;

   logic                  lat_op;
   logic                  lat_err;
   logic [DATA_WIDTH-1:0] lat_data;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [2:0]            lat_port;

   function automatic logic [2:0] wrap_idx(
      input logic [2:0] base,
      input int         k
   );
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[2:0];
   endfunction

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_idx(rr_ptr, k);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && cand == 3'(i)
                && bus.req_valid[i]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
   end

   assign hs = (state == IDLE) && gnt_found;

   always_comb begin
      ready    = '0;
      sel_op   = 1'b0;
      sel_data = '0;
      sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ready[i] = hs && (gnt_idx == 3'(i));
         if (gnt_idx == 3'(i)) begin
            sel_op   = bus.req_op[i];
            sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Downward scan so the lowest free index is the last one written.
   always_comb begin
      low_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_map[i]) low_idx = ADDR_WIDTH'(i);
      end
   end

   assign full_int = (free_cnt == '0);
   assign sel_err  = sel_op ? !valid_map[sel_addr] : full_int;
   assign tgt_addr = sel_op   ? sel_addr :
                     full_int ? '0       : low_idx;

   always_ff @(posedge clk) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cam_en    = 1'b0;
      unique case (state)
         INIT:  if (!bus.cam_write_busy) state_nxt = IDLE;
         IDLE:  if (hs) state_nxt = ISSUE;
         ISSUE: begin
            if (lat_err) begin
               state_nxt = RESP;
            end else if (!bus.cam_write_busy) begin
               cam_en    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (!wait_first && !bus.cam_write_busy)
               state_nxt = RESP;
         end
         RESP:  if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= '0;
         valid_map  <= '0;
         free_cnt   <= (ADDR_WIDTH+1)'(DEPTH);
         wait_first <= 1'b0;
         lat_op     <= 1'b0;
         lat_err    <= 1'b0;
         lat_data   <= '0;
         lat_addr   <= '0;
         lat_port   <= '0;
      end else begin
         wait_first <= cam_en;
         if (hs) begin
            rr_ptr   <= wrap_idx(gnt_idx, 1);
            lat_op   <= sel_op;
            lat_err  <= sel_err;
            lat_data <= sel_data;
            lat_addr <= tgt_addr;
            lat_port <= gnt_idx;
         end
         if (cam_en) begin
            valid_map[lat_addr] <= !lat_op;
            free_cnt <= lat_op ? free_cnt + 1'b1
                               : free_cnt - 1'b1;
         end
      end
   end

   assign bus.req_ready        = ready;
   assign bus.resp_valid       = (state == RESP);
   assign bus.resp_port        = lat_port;
   assign bus.resp_addr        = lat_addr;
   assign bus.resp_err         = lat_err;
   assign bus.cam_write_enable = cam_en;
   assign bus.cam_write_addr   = lat_addr;
   assign bus.cam_write_data   = lat_op ? '0 : lat_data;
   assign bus.cam_write_delete = lat_op;
   assign bus.free_count       = free_cnt;
   assign bus.full             = full_int;
endmodule
